adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_pkg.sv | 21 ++
 rtl/adc_next_channel.sv | 28 ++
 rtl/adc_scan_sequencer.sv | 153 +++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// ============================================================================
// adc_pkg : shared types and constants for the ADC scan sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package adc_pkg;

  localparam int ADC_NUM_CHANNELS = 9;
  localparam int ADC_CHAN_W       = 5;
  localparam logic [ADC_CHAN_W-1:0] ADC_TEMP_CHANNEL = 5'd17;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/adc_next_channel.sv
// ============================================================================
// adc_next_channel : lowest enabled channel above the current one, else 17
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_next_channel
  import adc_pkg::*;
(
  input  logic [ADC_NUM_CHANNELS-1:0] i_mask,
  input  logic [ADC_CHAN_W-1:0]       i_cur_chan,
  input  logic                        i_from_start,
  output logic [ADC_CHAN_W-1:0]       o_next_chan
);

  // Walk downwards so the lowest qualifying channel is the last one written.
  always_comb begin
    o_next_chan = ADC_TEMP_CHANNEL;
    for (int i = ADC_NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_from_start || (ADC_CHAN_W'(i) > i_cur_chan))) begin
        o_next_chan = ADC_CHAN_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
// ============================================================================
// adc_scan_sequencer : issues one ADC command per enabled channel, then ch 17
// Rev 1.0
// ============================================================================
`default_nettype none

module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int PERIOD_CYCLES  = 50000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       Clock_qsys,
  input  logic       Reset,
  input  logic       ScanEnable,
  input  logic       SingleScan,
  input  logic [8:0] ChannelMask,
  output logic       AdcCommandValid,
  output logic [4:0] AdcCommandChannel,
  output logic       AdcCommandStartOfPacket,
  output logic       AdcCommandEndOfPacket,
  input  logic       AdcCommandReady,
  input  logic       AdcResponseValid,
  input  logic [4:0] AdcResponseChannel,
  output logic       ScanBusy,
  output logic       ScanDone,
  output logic       ScanTimeout
);

  localparam int PW = $clog2(PERIOD_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  scan_state_e                 state_q, state_d;
  logic [ADC_CHAN_W-1:0]       chan_q, chan_d;
  logic [ADC_NUM_CHANNELS-1:0] mask_q, mask_d;
  logic                        sop_q, sop_d;
  logic [PW-1:0]               period_q, period_d;
  logic [TW-1:0]               tmo_q, tmo_d;
  logic                        done_q, done_d;
  logic                        timeout_q, timeout_d;

  logic [ADC_NUM_CHANNELS-1:0] finder_mask;
  logic                        finder_from_start;
  logic [ADC_CHAN_W-1:0]       next_chan;
  logic                        scan_start;
  logic                        tmo_expired;
  logic                        resp_match;

  // While idle the finder looks at the live mask so the first channel is
  // known at the start edge; during a scan only the latched copy counts.
  assign finder_from_start = (state_q == IDLE);
  assign finder_mask       = finder_from_start ? ChannelMask : mask_q;

  adc_next_channel u_next_channel (
    .i_mask       (finder_mask),
    .i_cur_chan   (chan_q),
    .i_from_start (finder_from_start),
    .o_next_chan  (next_chan)
  );

  assign scan_start  = (ScanEnable && (period_q == '0)) || SingleScan;
  assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign resp_match  = AdcResponseValid && (AdcResponseChannel == chan_q);

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    mask_d    = mask_q;
    sop_d     = sop_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    period_d  = (period_q != '0) ? period_q - 1'b1 : '0;

    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d  = ISSUE;
          chan_d   = next_chan;
          mask_d   = ChannelMask;
          sop_d    = 1'b1;
          period_d = PW'(PERIOD_CYCLES - 1);
        end
      end
      ISSUE: begin
        if (AdcCommandReady) begin
          state_d = WAIT_RESP;
          sop_d   = 1'b0;
        end else if (tmo_expired) begin
          state_d   = IDLE;
          sop_d     = 1'b0;
          timeout_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        if (resp_match) begin
          if (chan_q == ADC_TEMP_CHANNEL) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            chan_d  = next_chan;
          end
        end else if (tmo_expired) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Restarts on every state change, so each command gets a full budget.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge Clock_qsys) begin
    if (Reset) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      mask_q    <= '0;
      sop_q     <= 1'b0;
      period_q  <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      mask_q    <= mask_d;
      sop_q     <= sop_d;
      period_q  <= period_d;
      tmo_q     <= tmo_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign AdcCommandValid         = (state_q == ISSUE);
  assign AdcCommandChannel       = chan_q;
  assign AdcCommandStartOfPacket = AdcCommandValid && sop_q;
  assign AdcCommandEndOfPacket   = AdcCommandValid && (chan_q == ADC_TEMP_CHANNEL);
  assign ScanBusy                = (state_q != IDLE);
  assign ScanDone                = done_q;
  assign ScanTimeout             = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
// ============================================================================
// tb_adc_scan_sequencer : directed self-checking bench for adc_scan_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_adc_scan_sequencer;

  localparam int PERIOD  = 200;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_enable = 1'b0;
  logic       single_scan = 1'b0;
  logic [8:0] channel_mask = '0;
  logic       cmd_ready = 1'b0;
  logic       resp_valid = 1'b0;
  logic [4:0] resp_chan = '0;
  logic       cmd_valid;
  logic [4:0] cmd_chan;
  logic       cmd_sop;
  logic       cmd_eop;
  logic       scan_busy;
  logic       scan_done;
  logic       scan_timeout;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int tmo_cnt = 0;

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .Clock_qsys              (clk),
    .Reset                   (rst),
    .ScanEnable              (scan_enable),
    .SingleScan              (single_scan),
    .ChannelMask             (channel_mask),
    .AdcCommandValid         (cmd_valid),
    .AdcCommandChannel       (cmd_chan),
    .AdcCommandStartOfPacket (cmd_sop),
    .AdcCommandEndOfPacket   (cmd_eop),
    .AdcCommandReady         (cmd_ready),
    .AdcResponseValid        (resp_valid),
    .AdcResponseChannel      (resp_chan),
    .ScanBusy                (scan_busy),
    .ScanDone                (scan_done),
    .ScanTimeout             (scan_timeout)
  );

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    done_cnt <= done_cnt + ((scan_done === 1'b1) ? 1 : 0);
    tmo_cnt  <= tmo_cnt + ((scan_timeout === 1'b1) ? 1 : 0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound);
    int n;
    n = 0;
    while ((cmd_valid !== 1'b1) && (n < bound)) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_single();
    single_scan = 1'b1;
    @(negedge clk);
    single_scan = 1'b0;
    check("start_latency", cmd_valid, 1);
  endtask

  // One command: check it, optionally stall Ready, accept it, then answer
  // three cycles after the accept (optionally preceded by a stray channel-5).
  task automatic do_cmd(input logic [4:0] ch, input logic sop, input logic eop,
                        input int hold, input bit respond, input bit spur);
    wait_valid(100);
    check("cmd_valid", cmd_valid, 1);
    check("cmd_chan", cmd_chan, ch);
    check("cmd_sop", cmd_sop, sop);
    check("cmd_eop", cmd_eop, eop);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", cmd_valid, 1);
      check("hold_chan", cmd_chan, ch);
      check("hold_sop", cmd_sop, sop);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    check("accept_valid_low", cmd_valid, 0);
    check("accept_busy", scan_busy, 1);
    if (respond) begin
      if (spur) begin
        resp_valid = 1'b1;
        resp_chan  = 5'd5;
      end
      @(negedge clk);
      resp_valid = 1'b0;
      if (spur) check("spur_ignored", cmd_valid, 0);
      @(negedge clk);
      resp_valid = 1'b1;
      resp_chan  = ch;
      @(negedge clk);
      resp_valid = 1'b0;
      check("resp_done", scan_done, eop);
      check("resp_busy", scan_busy, !eop);
    end
  endtask

  initial begin
    int d0, t0, n, t1, vcnt;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", cmd_valid, 0);
    check("rst_chan", cmd_chan, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_done", scan_done, 0);
    check("rst_tmo", scan_timeout, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full mask: 0..8 then 17
    channel_mask = 9'h1FF;
    d0 = done_cnt;
    pulse_single();
    do_cmd(5'd0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) do_cmd(5'(c), 1'b0, 1'b0, 0, 1'b1, 1'b0);
    do_cmd(5'd17, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("full_done_count", done_cnt, d0 + 1);

    // Channels 2,4 with stalled Ready; mask change mid-scan ignored
    channel_mask = 9'b000010100;
    d0 = done_cnt;
    pulse_single();
    channel_mask = 9'h1FF;
    do_cmd(5'd2, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    do_cmd(5'd4, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    do_cmd(5'd17, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("stall_done_count", done_cnt, d0 + 1);

    // Empty mask: ch 17 only; SingleScan while busy not queued
    channel_mask = 9'h000;
    pulse_single();
    single_scan = 1'b1;
    @(negedge clk);
    single_scan = 1'b0;
    do_cmd(5'd17, 1'b1, 1'b1, 0, 1'b1, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1 || scan_busy === 1'b1) vcnt++;
    end
    check("busy_single_ignored", vcnt, 0);

    // Timeout: no response to channel 0
    channel_mask = 9'h001;
    d0 = done_cnt;
    pulse_single();
    do_cmd(5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    n = 0;
    while ((scan_timeout !== 1'b1) && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n, TIMEOUT);
    check("timeout_busy", scan_busy, 0);
    check("timeout_valid", cmd_valid, 0);
    @(negedge clk);
    check("timeout_pulse_width", scan_timeout, 0);
    repeat (3) @(negedge clk);
    check("timeout_no_done", done_cnt, d0);

    // Continuous mode, channel 3, stray channel-5 response during the wait
    channel_mask = 9'b000001000;
    scan_enable  = 1'b1;
    wait_valid(300);
    t0 = cyc;
    do_cmd(5'd3, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    do_cmd(5'd17, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    wait_valid(300);
    t1 = cyc;
    check("period_spacing", t1 - t0, PERIOD);
    scan_enable = 1'b0;
    d0 = done_cnt;
    do_cmd(5'd3, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    do_cmd(5'd17, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (cmd_valid === 1'b1) vcnt++;
    end
    check("enable_low_completes", done_cnt, d0 + 1);
    check("enable_low_no_restart", vcnt, 0);

    // Reset while waiting for a response
    channel_mask = 9'h003;
    d0 = done_cnt;
    t0 = tmo_cnt;
    pulse_single();
    do_cmd(5'd0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", cmd_valid, 0);
    check("mid_rst_chan", cmd_chan, 0);
    check("mid_rst_sop", cmd_sop, 0);
    check("mid_rst_eop", cmd_eop, 0);
    check("mid_rst_busy", scan_busy, 0);
    check("mid_rst_done", scan_done, 0);
    check("mid_rst_tmo", scan_timeout, 0);
    rst = 1'b0;
    resp_valid = 1'b1;
    resp_chan  = 5'd0;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("late_resp_no_done", done_cnt, d0);
    check("late_resp_no_tmo", tmo_cnt, t0);
    check("late_resp_idle", scan_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
